// File: rtl/dday_seq_pkg.sv
// dday_seq_pkg: shared definitions for the D-day controller.
//   - date field slices of the packed 23-bit date {year[13:0], month[3:0], day[4:0]}
//   - FSM state encoding
//   - leading-zero blank masks for the four-digit display
package dday_seq_pkg;

  localparam int DATE_W    = 23;
  localparam int YEAR_MSB  = 22;
  localparam int YEAR_LSB  = 9;
  localparam int MONTH_MSB = 8;
  localparam int MONTH_LSB = 5;
  localparam int DAY_MSB   = 4;
  localparam int DAY_LSB   = 0;

  // Width of the binary value handed to the serial BCD converter (9999 < 2^14).
  localparam int BCD_IN_W  = 14;
  localparam int BCD_W     = 16;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CONV_NOW = 3'd1;
  localparam logic [2:0] S_CONV_SET = 3'd2;
  localparam logic [2:0] S_DIFF     = 3'd3;
  localparam logic [2:0] S_BCD      = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = S_IDLE,
    ST_CONV_NOW = S_CONV_NOW,
    ST_CONV_SET = S_CONV_SET,
    ST_DIFF     = S_DIFF,
    ST_BCD      = S_BCD,
    ST_DONE     = S_DONE
  } state_t;

  // Bit i set = digit i blank. Digit 0 is always shown.
  localparam logic [3:0] BLANK_1DIG = 4'b1110;
  localparam logic [3:0] BLANK_2DIG = 4'b1100;
  localparam logic [3:0] BLANK_3DIG = 4'b1000;
  localparam logic [3:0] BLANK_NONE = 4'b0000;

endpackage

// File: rtl/days_sum.sv
// days_sum: combinational conversion of a packed date to an absolute day count
// (Gregorian, counted from a fixed proleptic origin; only differences matter).
// Ports:
//   date  in  23       {year[13:0], month[3:0], day[4:0]}
//   days  out DAYS_W   absolute day number
// With DAYS_W = 22 the count stays below 2^22 for years up to about 11400.
module days_sum
  import dday_seq_pkg::*;
#(
  parameter int DAYS_W = 22
) (
  input  logic [DATE_W-1:0] date,
  output logic [DAYS_W-1:0] days
);

  logic [DAYS_W-1:0] year;
  logic [DAYS_W-1:0] day;
  logic [DAYS_W-1:0] cum;
  logic [DAYS_W-1:0] leap_adj;
  logic              leap;

  always_comb begin
    year = DAYS_W'(date[YEAR_MSB:YEAR_LSB]);
    day  = DAYS_W'(date[DAY_MSB:DAY_LSB]);
    leap = ((year % DAYS_W'(4)) == '0 && (year % DAYS_W'(100)) != '0)
           || (year % DAYS_W'(400)) == '0;

    // Days in the year preceding the first of each month (non-leap).
    case (date[MONTH_MSB:MONTH_LSB])
      4'd2:    cum = DAYS_W'(31);
      4'd3:    cum = DAYS_W'(59);
      4'd4:    cum = DAYS_W'(90);
      4'd5:    cum = DAYS_W'(120);
      4'd6:    cum = DAYS_W'(151);
      4'd7:    cum = DAYS_W'(181);
      4'd8:    cum = DAYS_W'(212);
      4'd9:    cum = DAYS_W'(243);
      4'd10:   cum = DAYS_W'(273);
      4'd11:   cum = DAYS_W'(304);
      4'd12:   cum = DAYS_W'(334);
      default: cum = '0;
    endcase

    // The year/4 - year/100 + year/400 term already counts this year's leap
    // day; it has not happened yet in January and February.
    leap_adj = (leap && date[MONTH_MSB:MONTH_LSB] <= 4'd2) ? DAYS_W'(1) : '0;

    days = DAYS_W'(365) * year + year / DAYS_W'(4) - year / DAYS_W'(100)
           + year / DAYS_W'(400) + cum + day - leap_adj;
  end

endmodule

// File: rtl/dday_seq_bcd_serial.sv
// bcd_serial: 14-bit binary to 4-digit BCD, one double-dabble iteration per clock.
// Ports:
//   clk, rst  clock, async active-high reset
//   start     load bin on this edge; iterations run on the following 14 edges
//   bin       14-bit binary input (values up to 9999)
//   done      high in the cycle whose closing edge performs the final iteration
//   bcd       result of the iteration performed on the next edge; final value when done=1
module bcd_serial
  import dday_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BCD_IN_W-1:0] bin,
  output logic                done,
  output logic [BCD_W-1:0]    bcd
);

  logic [BCD_IN_W-1:0] sh;
  logic [BCD_W-1:0]    acc;
  logic [3:0]          cnt;
  logic                run;

  // Add 3 to every nibble >= 5. The accumulator never exceeds 4999 before the
  // last shift, so the top bit is always zero and is dropped here.
  function automatic logic [BCD_W-2:0] dabble(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r[BCD_W-2:0];
  endfunction

  // Exposed combinationally so the caller can register the result on the
  // same edge as the final iteration.
  assign bcd  = {dabble(acc), sh[BCD_IN_W-1]};
  assign done = run && (cnt == 4'(BCD_IN_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh  <= '0;
      acc <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      sh  <= bin;
      acc <= '0;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      acc <= bcd;
      sh  <= {sh[BCD_IN_W-2:0], 1'b0};
      cnt <= cnt + 4'd1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/dday_seq.sv
// dday_seq: sequential D-day controller. On a trigger it snapshots both dates,
// converts them one after the other through a single days_sum instance, forms
// the signed difference, classifies it, and converts it to BCD serially.
// Ports:
//   clk, rst   clock, async active-high reset
//   start      computation request (honoured only in IDLE/DONE)
//   now_date   current date  {year[13:0], month[3:0], day[4:0]}
//   set_date   target date   same format
//   busy       high from the accept edge until the done pulse
//   done       one-cycle pulse; results valid from this cycle on
//   sign       0: now <= set ("D-"), 1: now > set ("D+")
//   diff       |set_days - now_days|
//   bcd        four BCD digits of diff, zero when long
//   blank      leading-zero mask, bit i = digit i blank
//   zero       diff == 0
//   long       diff > MAX_SHOW
module dday_seq
  import dday_seq_pkg::*;
#(
  parameter int AUTO_REFRESH = 1,
  parameter int DAYS_W       = 22,
  parameter int MAX_SHOW     = 9999
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATE_W-1:0] now_date,
  input  logic [DATE_W-1:0] set_date,
  output logic              busy,
  output logic              done,
  output logic              sign,
  output logic [DAYS_W-1:0] diff,
  output logic [BCD_W-1:0]  bcd,
  output logic [3:0]        blank,
  output logic              zero,
  output logic              long
);

  state_t            state;
  logic [DATE_W-1:0] now_snap;
  logic [DATE_W-1:0] set_snap;
  logic [DAYS_W-1:0] now_days;
  logic [DAYS_W-1:0] set_days;
  logic [DATE_W-1:0] conv_date;
  logic [DAYS_W-1:0] conv_days;

  logic              trigger;
  logic              accept;

  logic              sign_c;
  logic [DAYS_W-1:0] diff_c;
  logic              long_c;

  logic              bcd_start;
  logic              bcd_done;
  logic [BCD_W-1:0]  bcd_val;

  function automatic logic [3:0] blank_mask(input logic [DAYS_W-1:0] d);
    if (d < DAYS_W'(10))        return BLANK_1DIG;
    else if (d < DAYS_W'(100))  return BLANK_2DIG;
    else if (d < DAYS_W'(1000)) return BLANK_3DIG;
    else                        return BLANK_NONE;
  endfunction

  // One converter shared in time: now_snap in CONV_NOW, set_snap in CONV_SET.
  assign conv_date = (state == ST_CONV_SET) ? set_snap : now_snap;

  days_sum #(.DAYS_W(DAYS_W)) u_days_sum (
    .date (conv_date),
    .days (conv_days)
  );

  // Auto refresh compares live inputs against the snapshot of the last accepted
  // request, so a date that changed while busy re-triggers once idle/done.
  assign trigger = start
                   || ((AUTO_REFRESH != 0) && ((now_date != now_snap) || (set_date != set_snap)));
  assign accept  = trigger && (state == ST_IDLE || state == ST_DONE);

  always_comb begin
    sign_c = now_days > set_days;
    diff_c = sign_c ? (now_days - set_days) : (set_days - now_days);
    long_c = diff_c > DAYS_W'(MAX_SHOW);
  end

  assign bcd_start = (state == ST_DIFF) && !long_c;

  bcd_serial u_bcd_serial (
    .clk   (clk),
    .rst   (rst),
    .start (bcd_start),
    .bin   (diff_c[BCD_IN_W-1:0]),
    .done  (bcd_done),
    .bcd   (bcd_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sign     <= 1'b0;
      diff     <= '0;
      bcd      <= '0;
      blank    <= BLANK_1DIG;
      zero     <= 1'b0;
      long     <= 1'b0;
      now_snap <= '0;
      set_snap <= '0;
      now_days <= '0;
      set_days <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            now_snap <= now_date;
            set_snap <= set_date;
            busy     <= 1'b1;
            state    <= ST_CONV_NOW;
          end
        end
        ST_CONV_NOW: begin
          now_days <= conv_days;
          state    <= ST_CONV_SET;
        end
        ST_CONV_SET: begin
          set_days <= conv_days;
          state    <= ST_DIFF;
        end
        ST_DIFF: begin
          diff <= diff_c;
          sign <= sign_c;
          zero <= (diff_c == '0);
          long <= long_c;
          if (long_c) begin
            bcd   <= '0;
            blank <= BLANK_NONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            state <= ST_BCD;
          end
        end
        ST_BCD: begin
          if (bcd_done) begin
            bcd   <= bcd_val;
            blank <= blank_mask(diff);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dday_seq.sv
// tb_dday_seq: directed and randomized checks of dday_seq against a calendar
// model based on Julian day numbers.
module tb_dday_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [22:0] now_date;
  logic [22:0] set_date;
  logic        busy;
  logic        done;
  logic        sign;
  logic [21:0] diff;
  logic [15:0] bcd;
  logic [3:0]  blank;
  logic        zero;
  logic        long;

  int checks = 0;
  int errors = 0;

  dday_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .now_date (now_date),
    .set_date (set_date),
    .busy     (busy),
    .done     (done),
    .sign     (sign),
    .diff     (diff),
    .bcd      (bcd),
    .blank    (blank),
    .zero     (zero),
    .long     (long)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] mkdate(input int y, input int m, input int d);
    logic [13:0] yy;
    logic [3:0]  mm;
    logic [4:0]  dd;
    yy = y[13:0];
    mm = m[3:0];
    dd = d[4:0];
    return {yy, mm, dd};
  endfunction

  // Julian day number of a Gregorian date.
  function automatic int jdn(input int y, input int m, input int d);
    int a, yy, mm;
    a  = (14 - m) / 12;
    yy = y + 4800 - a;
    mm = m + 12 * a - 3;
    return d + (153 * mm + 2) / 5 + 365 * yy + yy / 4 - yy / 100 + yy / 400 - 32045;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts edges from the accept edge (counted as 1) until done is seen.
  task automatic await_done(input string tag, output int edges);
    edges = 1;
    while (edges < 60) begin
      @(posedge clk);
      edges++;
      #1;
      if (done) break;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic expect_result(input string tag, input int ny, input int nm, input int nd,
                               input int sy, input int sm, input int sd);
    int          dn, ds, dd, tmp, ndig;
    logic [15:0] eb;
    logic [3:0]  ebl;
    logic        es, el;
    dn  = jdn(ny, nm, nd);
    ds  = jdn(sy, sm, sd);
    es  = dn > ds;
    dd  = es ? dn - ds : ds - dn;
    el  = dd > 9999;
    eb  = '0;
    tmp = dd;
    for (int i = 0; i < 4; i++) begin
      eb[4*i +: 4] = 4'(tmp % 10);
      tmp = tmp / 10;
    end
    ndig = 1;
    tmp  = dd;
    while (tmp >= 10) begin
      ndig++;
      tmp = tmp / 10;
    end
    ebl = 4'b1111;
    ebl = ebl << ndig;
    if (el) begin
      eb  = '0;
      ebl = 4'b0000;
    end
    check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_sign"},  {31'd0, sign}, {31'd0, es});
    check({tag, "_diff"},  {10'd0, diff}, dd);
    check({tag, "_zero"},  {31'd0, zero}, {31'd0, (dd == 0)});
    check({tag, "_long"},  {31'd0, long}, {31'd0, el});
    check({tag, "_bcd"},   {16'd0, bcd},  {16'd0, eb});
    check({tag, "_blank"}, {28'd0, blank}, {28'd0, ebl});
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_pair(input string tag, input int ny, input int nm, input int nd,
                          input int sy, input int sm, input int sd);
    int edges, dd;
    now_date = mkdate(ny, nm, nd);
    set_date = mkdate(sy, sm, sd);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    await_done(tag, edges);
    dd = jdn(ny, nm, nd) - jdn(sy, sm, sd);
    if (dd < 0) dd = -dd;
    check({tag, "_latency"}, edges, (dd > 9999) ? 32'd4 : 32'd18);
    expect_result(tag, ny, nm, nd, sy, sm, sd);
    @(negedge clk);
  endtask

  initial begin
    int edges, y, m, d, sy, sm, sd;
    rst      = 1'b0;
    start    = 1'b0;
    now_date = '0;
    set_date = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_done",  {31'd0, done},  32'd0);
    check("rst_diff",  {10'd0, diff},  32'd0);
    check("rst_bcd",   {16'd0, bcd},   32'd0);
    check("rst_blank", {28'd0, blank}, 32'he);
    check("rst_flags", {29'd0, sign, zero, long}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_pair("t1", 2024, 3, 1, 2024, 3, 11);
    check("t1_bcd_const", {16'd0, bcd}, 32'h0010);
    @(posedge clk);
    #1 check("t1_done_width", {31'd0, done}, 32'd0);
    check("t1_stay_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);

    run_pair("back1", 2024, 1, 1, 2023, 12, 31);
    run_pair("equal", 2024, 5, 5, 2024, 5, 5);
    run_pair("long", 2000, 1, 1, 2030, 1, 1);
    run_pair("d9999", 2000, 1, 1, 2027, 5, 18);
    check("d9999_bcd_const", {16'd0, bcd}, 32'h9999);
    run_pair("d10000", 2000, 1, 1, 2027, 5, 19);

    for (int i = 0; i < 8; i++) begin
      y  = 1990 + int'($urandom_range(0, 30));
      m  = int'($urandom_range(1, 12));
      d  = int'($urandom_range(1, 28));
      sy = (i % 2 == 0) ? y - 2 + int'($urandom_range(0, 4)) : y + int'($urandom_range(0, 40));
      sm = int'($urandom_range(1, 12));
      sd = int'($urandom_range(1, 28));
      run_pair($sformatf("rnd%0d", i), y, m, d, sy, sm, sd);
    end

    // Request changes while busy are ignored; auto refresh picks them up after done.
    now_date = mkdate(2024, 3, 1);
    set_date = mkdate(2024, 6, 1);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    set_date = mkdate(2024, 3, 5);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = 0;
    await_done("busy_ign", edges);
    edges = edges + 7;
    check("busy_ign_latency", edges, 32'd18);
    expect_result("busy_ign", 2024, 3, 1, 2024, 6, 1);
    @(posedge clk);
    #1 check("auto_busy", {31'd0, busy}, 32'd1);
    await_done("auto", edges);
    check("auto_latency", edges, 32'd18);
    expect_result("auto", 2024, 3, 1, 2024, 3, 5);
    @(negedge clk);

    // Reset in the middle of the BCD phase.
    now_date = mkdate(2024, 1, 10);
    set_date = mkdate(2025, 2, 1);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_busy",  {31'd0, busy},  32'd0);
    check("mrst_done",  {31'd0, done},  32'd0);
    check("mrst_diff",  {10'd0, diff},  32'd0);
    check("mrst_bcd",   {16'd0, bcd},   32'd0);
    check("mrst_blank", {28'd0, blank}, 32'he);
    check("mrst_flags", {29'd0, sign, zero, long}, 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1 check("mrst_no_done", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    run_pair("post_rst", 2024, 1, 10, 2025, 2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
